// File: rtl/mac_tile_pkg.sv
// Shared types and helpers for the DSP-column multiplier/MAC tile.
// Stage products are carried sign-extended to PROD_MAX_W, so ACC_W must not exceed it.
package mac_tile_pkg;

    localparam int unsigned PROD_MAX_W = 128;

    typedef enum logic [1:0] {
        MODE_UMUL = 2'b00,
        MODE_SMUL = 2'b01,
        MODE_UMAC = 2'b10,
        MODE_SMAC = 2'b11
    } mac_mode_e;

    typedef struct packed {
        logic                  valid;
        logic                  clr;
        mac_mode_e             mode;
        logic [PROD_MAX_W-1:0] product;
    } mac_stage_t;

    function automatic int unsigned acc_width(input int unsigned width, input int unsigned guard);
        return 2 * width + guard;
    endfunction

    function automatic logic mode_is_mac(input mac_mode_e m);
        return m[1];
    endfunction

    function automatic logic mode_is_signed(input mac_mode_e m);
        return m[0];
    endfunction

endpackage

// File: rtl/mac_tile_pipe_stage.sv
// One clock-enabled, synchronously reset product pipeline register.
module mac_tile_pipe_stage
    import mac_tile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  mac_stage_t d,
    output mac_stage_t q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (ce) begin
            q <= d;
        end
    end

endmodule

// File: rtl/logical_tile_mult_n_mode_mac_.sv
// Pipelined WIDTH x WIDTH signed/unsigned multiplier with accumulate modes.
// Build option: MAC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module logical_tile_mult_n_mode_mac_
    import mac_tile_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned PIPE_STAGES = 1,
    parameter int unsigned GUARD       = 8
) (
    input  logic                                 mac_clk,
    input  logic                                 mac_reset,
    input  logic                                 mac_ce,
    input  logic [1:0]                           mac_mode,
    input  logic [WIDTH-1:0]                     mac_a,
    input  logic [WIDTH-1:0]                     mac_b,
    input  logic                                 mac_in_valid,
    input  logic                                 mac_acc_clr,
    output logic [acc_width(WIDTH, GUARD)-1:0]   mac_out,
    output logic                                 mac_out_valid,
    output logic                                 mac_ovf
);

    localparam int unsigned ACC_W = acc_width(WIDTH, GUARD);
    localparam int unsigned PW    = 2 * WIDTH + 2;

    logic               op_valid;
    logic               op_clr;
    mac_mode_e          op_mode;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;

    // Input capture; bubbles and clear-only slots travel as valid=0.
    always_ff @(posedge mac_clk) begin
        if (mac_reset) begin
            op_valid <= 1'b0;
            op_clr   <= 1'b0;
            op_mode  <= MODE_UMUL;
            op_a     <= '0;
            op_b     <= '0;
        end else if (mac_ce) begin
            op_valid <= mac_in_valid;
            op_clr   <= mac_acc_clr;
            op_mode  <= mac_mode_e'(mac_mode);
            op_a     <= mac_a;
            op_b     <= mac_b;
        end
    end

    logic signed [WIDTH:0]  a_x;
    logic signed [WIDTH:0]  b_x;
    logic signed [PW-1:0]   prod;
    mac_stage_t             stage_in;

    // One extra operand bit turns both signednesses into a single signed multiply.
    always_comb begin
        a_x = $signed({mode_is_signed(op_mode) & op_a[WIDTH-1], op_a});
        b_x = $signed({mode_is_signed(op_mode) & op_b[WIDTH-1], op_b});
        prod = PW'(a_x) * PW'(b_x);
        stage_in.valid   = op_valid;
        stage_in.clr     = op_clr;
        stage_in.mode    = op_mode;
        stage_in.product = PROD_MAX_W'(prod);
    end

    mac_stage_t pipe [0:PIPE_STAGES];
    mac_stage_t fin;

    assign pipe[0] = stage_in;

    for (genvar i = 0; i < int'(PIPE_STAGES); i++) begin : g_pipe
        mac_tile_pipe_stage u_stage (
            .clk   (mac_clk),
            .reset (mac_reset),
            .ce    (mac_ce),
            .d     (pipe[i]),
            .q     (pipe[i+1])
        );
    end

    assign fin = pipe[PIPE_STAGES];

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_n;
    logic [ACC_W-1:0] out_n;
    logic [ACC_W-1:0] p;
    logic [ACC_W:0]   sum;
    logic             ovf_add;
    logic             ovf_n;
`ifdef MAC_SATURATE_EN
    logic [ACC_W-1:0] sat;
`endif

    // Output stage: accumulator update, overflow detection and result select.
    always_comb begin
        acc_n = acc;
        out_n = mac_out;
        ovf_n = mac_ovf;
        p     = ACC_W'(fin.product);
        sum   = {1'b0, acc} + {1'b0, p};
        if (mode_is_signed(fin.mode)) begin
            ovf_add = (acc[ACC_W-1] == p[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
        end else begin
            ovf_add = sum[ACC_W];
        end
`ifdef MAC_SATURATE_EN
        if (!mode_is_signed(fin.mode)) begin
            sat = '1;
        end else if (p[ACC_W-1]) begin
            sat = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            sat = {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
        if (fin.valid) begin
            if (!mode_is_mac(fin.mode)) begin
                out_n = p;
            end else if (fin.clr) begin
                acc_n = p;
                out_n = p;
                ovf_n = 1'b0;
            end else begin
                acc_n = sum[ACC_W-1:0];
                if (ovf_add) begin
                    ovf_n = 1'b1;
`ifdef MAC_SATURATE_EN
                    acc_n = sat;
`endif
                end
                out_n = acc_n;
            end
        end else if (fin.clr) begin
            acc_n = '0;
            ovf_n = 1'b0;
        end
    end

    always_ff @(posedge mac_clk) begin
        if (mac_reset) begin
            acc           <= '0;
            mac_out       <= '0;
            mac_out_valid <= 1'b0;
            mac_ovf       <= 1'b0;
        end else if (mac_ce) begin
            acc           <= acc_n;
            mac_out       <= out_n;
            mac_out_valid <= fin.valid;
            mac_ovf       <= ovf_n;
        end
    end

endmodule

// File: tb/tb_logical_tile_mult_n_mode_mac_.sv
// Scoreboard bench for logical_tile_mult_n_mode_mac_ (WIDTH=8, PIPE_STAGES=1, GUARD=8).
// Honours MAC_SATURATE_EN for the overflow expectations.
module tb_logical_tile_mult_n_mode_mac_;

    localparam int unsigned ACC_W = 24;
    localparam int          LAT   = 2;

    logic             mac_clk = 1'b0;
    logic             mac_reset;
    logic             mac_ce;
    logic [1:0]       mac_mode;
    logic [7:0]       mac_a;
    logic [7:0]       mac_b;
    logic             mac_in_valid;
    logic             mac_acc_clr;
    logic [ACC_W-1:0] mac_out;
    logic             mac_out_valid;
    logic             mac_ovf;

    typedef struct {
        logic [ACC_W-1:0] out;
        logic             ovf;
        int               edge_n;
    } exp_t;

    exp_t exp_q [$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    logic en;
    exp_t e;

    logical_tile_mult_n_mode_mac_ #(.WIDTH(8), .PIPE_STAGES(1), .GUARD(8)) dut (
        .mac_clk       (mac_clk),
        .mac_reset     (mac_reset),
        .mac_ce        (mac_ce),
        .mac_mode      (mac_mode),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_in_valid  (mac_in_valid),
        .mac_acc_clr   (mac_acc_clr),
        .mac_out       (mac_out),
        .mac_out_valid (mac_out_valid),
        .mac_ovf       (mac_ovf)
    );

    always #5 mac_clk = ~mac_clk;

    // Monitor: pops one expectation per enabled edge that presents a valid output.
    always @(posedge mac_clk) begin
        en = mac_ce && !mac_reset;
        if (en) edge_cnt++;
        #1;
        if (en && mac_out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: got out=%h ovf=%b at edge %0d, none required",
                         mac_out, mac_ovf, edge_cnt);
            end else begin
                e = exp_q.pop_front();
                if (mac_out !== e.out || mac_ovf !== e.ovf || edge_cnt != e.edge_n) begin
                    failures++;
                    $display("FAIL output: got out=%h ovf=%b edge=%0d, required out=%h ovf=%b edge=%0d",
                             mac_out, mac_ovf, edge_cnt, e.out, e.ovf, e.edge_n);
                end
            end
        end
    end

    task automatic check(input string name, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Drive one slot for one enabled cycle; push the expected result when one should emerge.
    task automatic op(input logic [1:0] mode, input logic [7:0] a, input logic [7:0] b,
                      input logic clr, input logic valid, input logic push,
                      input logic [ACC_W-1:0] exp_out, input logic exp_ovf);
        exp_t x;
        mac_ce       = 1'b1;
        mac_mode     = mode;
        mac_a        = a;
        mac_b        = b;
        mac_acc_clr  = clr;
        mac_in_valid = valid;
        if (push) begin
            x.out    = exp_out;
            x.ovf    = exp_ovf;
            x.edge_n = edge_cnt + 1 + LAT;
            exp_q.push_back(x);
        end
        @(negedge mac_clk);
    endtask

    task automatic idle(input int n);
        mac_ce       = 1'b1;
        mac_in_valid = 1'b0;
        mac_acc_clr  = 1'b0;
        repeat (n) @(negedge mac_clk);
    endtask

    longint acc_m;
    logic   ov_m;

    initial begin
        mac_reset    = 1'b1;
        mac_ce       = 1'b0;
        mac_mode     = 2'b00;
        mac_a        = '0;
        mac_b        = '0;
        mac_in_valid = 1'b0;
        mac_acc_clr  = 1'b0;
        repeat (2) @(negedge mac_clk);
        check("reset_out", mac_out, 24'h0);
        check("reset_valid", ACC_W'(mac_out_valid), 24'h0);
        check("reset_ovf", ACC_W'(mac_ovf), 24'h0);
        mac_reset = 1'b0;
        idle(2);

        // Multiplies, unsigned and signed.
        op(2'b00, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 24'd65025, 1'b0);
        idle(3);
        op(2'b01, 8'h80, 8'h80, 1'b0, 1'b1, 1'b1, 24'd16384, 1'b0);
        op(2'b01, 8'hFF, 8'h7F, 1'b0, 1'b1, 1'b1, 24'hFFFF81, 1'b0);
        idle(3);

        // Back-to-back unsigned accumulate.
        op(2'b10, 8'd3, 8'd4, 1'b1, 1'b1, 1'b1, 24'd12, 1'b0);
        op(2'b10, 8'd5, 8'd6, 1'b0, 1'b1, 1'b1, 24'd42, 1'b0);
        op(2'b10, 8'd7, 8'd8, 1'b0, 1'b1, 1'b1, 24'd98, 1'b0);

        // Clock-enable stall mid-stream; offered operands must be ignored.
        op(2'b10, 8'd1, 8'd1, 1'b0, 1'b1, 1'b1, 24'd99, 1'b0);
        op(2'b10, 8'd2, 8'd2, 1'b0, 1'b1, 1'b1, 24'd103, 1'b0);
        mac_ce = 1'b0; mac_in_valid = 1'b1; mac_a = 8'd9; mac_b = 8'd9;
        repeat (3) @(negedge mac_clk);
        op(2'b10, 8'd3, 8'd3, 1'b0, 1'b1, 1'b1, 24'd112, 1'b0);
        idle(3);

        // Clear-only slot, then accumulate from zero.
        op(2'b10, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0);
        op(2'b10, 8'd5, 8'd6, 1'b0, 1'b1, 1'b1, 24'd30, 1'b0);
        // A multiply leaves the accumulator alone.
        op(2'b00, 8'd2, 8'd2, 1'b0, 1'b1, 1'b1, 24'd4, 1'b0);
        op(2'b10, 8'd1, 8'd1, 1'b0, 1'b1, 1'b1, 24'd31, 1'b0);
        // Mode changes share the accumulator bits.
        op(2'b11, 8'd2, 8'hFD, 1'b1, 1'b1, 1'b1, 24'hFFFFFA, 1'b0);
        op(2'b10, 8'd1, 8'd1, 1'b0, 1'b1, 1'b1, 24'hFFFFFB, 1'b0);
        op(2'b11, 8'd3, 8'd3, 1'b0, 1'b1, 1'b1, 24'h000004, 1'b0);
        idle(3);

        // Signed accumulate past +2^23-1: 521st product overflows.
        acc_m = 0;
        ov_m  = 1'b0;
        for (int k = 0; k < 530; k++) begin
            if (k == 0) begin
                acc_m = 16129;
            end else begin
                acc_m = acc_m + 16129;
                if (acc_m > 64'sd8388607) begin
                    ov_m = 1'b1;
`ifdef MAC_SATURATE_EN
                    acc_m = 8388607;
`else
                    acc_m = acc_m - 64'sd16777216;
`endif
                end
            end
            op(2'b11, 8'h7F, 8'h7F, k == 0, 1'b1, 1'b1, ACC_W'(acc_m), ov_m);
        end
        op(2'b11, 8'd1, 8'd1, 1'b1, 1'b1, 1'b1, 24'd1, 1'b0);
        idle(3);

        // Reset with two ops in flight: they must never emerge.
        op(2'b00, 8'd2, 8'd3, 1'b0, 1'b1, 1'b0, 24'd0, 1'b0);
        op(2'b00, 8'd4, 8'd5, 1'b0, 1'b1, 1'b0, 24'd0, 1'b0);
        mac_reset = 1'b1; mac_in_valid = 1'b0;
        @(negedge mac_clk);
        check("flush_out", mac_out, 24'h0);
        check("flush_valid", ACC_W'(mac_out_valid), 24'h0);
        check("flush_ovf", ACC_W'(mac_ovf), 24'h0);
        mac_reset = 1'b0;
        idle(6);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending: got %0d outputs still outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
